// File: rtl/lane_adder_pipe.sv
// lane_adder_pipe: LANES independent W-bit add/sub lanes behind a STAGES-deep valid/ready pipe.
// Define LANE_ADDER_SAT_EN to make mode 11 an unsigned saturating add (default: wrapping add).
module lane_adder_pipe #(
  parameter int W      = 16,
  parameter int LANES  = 2,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [LANES*W-1:0]   a,
  input  logic [LANES*W-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   y,
  output logic [LANES-1:0]     flag,
  output logic [15:0]          txn_count
);

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_ADD1 = 2'b01,
    MODE_SUB  = 2'b10,
    MODE_EXT  = 2'b11
  } mode_e;

  localparam int LW = LANES * W;

  mode_e              mode_sel;
  logic [LW-1:0]      y_d;
  logic [LANES-1:0]   flag_d;
  logic [STAGES-1:0]  valid_q;
  logic [LW-1:0]      y_q    [STAGES];
  logic [LANES-1:0]   flag_q [STAGES];
  logic [STAGES-1:0]  stage_rdy;
  logic [15:0]        txn_count_q;

  assign mode_sel = mode_e'(mode);

  // Results are computed at acceptance, so mode travels implicitly with its operands.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin : lane_alu
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W:0]   sum;
    logic [W:0]   diff;
    y_d    = '0;
    flag_d = '0;
    op_a   = '0;
    op_b   = '0;
    sum    = '0;
    diff   = '0;
    for (int k = 0; k < LANES; k++) begin
      op_a = a[k*W +: W];
      op_b = b[k*W +: W];
      sum  = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, (mode_sel == MODE_ADD1)};
      diff = {1'b0, op_a} - {1'b0, op_b};
      case (mode_sel)
        MODE_SUB: begin
          y_d[k*W +: W] = diff[W-1:0];
          flag_d[k]     = diff[W];
        end
`ifdef LANE_ADDER_SAT_EN
        MODE_EXT: begin
          y_d[k*W +: W] = sum[W] ? {W{1'b1}} : sum[W-1:0];
          flag_d[k]     = sum[W];
        end
`endif
        default: begin
          y_d[k*W +: W] = sum[W-1:0];
          flag_d[k]     = sum[W];
        end
      endcase
    end
  end

  // A stage may load when it is empty or its contents move on this edge.
  always_comb begin : ready_chain
    logic chain;
    stage_rdy = '0;
    chain     = !valid_q[STAGES-1] || out_ready;
    stage_rdy[STAGES-1] = chain;
    for (int k = STAGES - 2; k >= 0; k--) begin
      chain        = !valid_q[k] || chain;
      stage_rdy[k] = chain;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the data stages are
  // reset as well so y reads 0 out of reset rather than stale contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      txn_count_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        y_q[k]    <= '0;
        flag_q[k] <= '0;
      end
    end else begin
      if (stage_rdy[0]) begin
        valid_q[0] <= in_valid;
        y_q[0]     <= y_d;
        flag_q[0]  <= flag_d;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (stage_rdy[k]) begin
          valid_q[k] <= valid_q[k-1];
          y_q[k]     <= y_q[k-1];
          flag_q[k]  <= flag_q[k-1];
        end
      end
      if (valid_q[STAGES-1] && out_ready) begin
        txn_count_q <= txn_count_q + 16'd1;
      end
    end
  end

  assign in_ready  = stage_rdy[0];
  assign out_valid = valid_q[STAGES-1];
  assign y         = y_q[STAGES-1];
  assign flag      = flag_q[STAGES-1];
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_lane_adder_pipe.sv
// Scoreboard bench for lane_adder_pipe: the driver queues hand-computed results on acceptance,
// an independent monitor pops and compares on every delivery and checks stability while stalled.
module tb_lane_adder_pipe;

  localparam int W      = 16;
  localparam int LANES  = 2;
  localparam int STAGES = 2;
  localparam int LW     = LANES * W;

  typedef struct packed {
    logic [LW-1:0]    y;
    logic [LANES-1:0] flag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [LW-1:0]    a;
  logic [LW-1:0]    b;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    y;
  logic [LANES-1:0] flag;
  logic [15:0]      txn_count;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   saw_in_ready_low = 1'b0;

  always #5 clk = ~clk;

  lane_adder_pipe #(.W(W), .LANES(LANES), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flag      (flag),
    .txn_count (txn_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Present one operand set; returns 1ns after the accepting edge with in_valid still high.
  task automatic send(input logic [1:0] m, input logic [LW-1:0] va, input logic [LW-1:0] vb,
                      input logic [LW-1:0] ey, input logic [LANES-1:0] ef);
    exp_t e;
    e.y = ey;
    e.flag = ef;
    mode = m;
    a = va;
    b = vb;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
      saw_in_ready_low = 1'b1;
      @(posedge clk);
      #1;
    end
    fail_now("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0 && !out_valid) return;
      @(posedge clk);
      #1;
    end
    fail_now("drain_timeout");
  endtask

  // Called just after the accepting edge with an otherwise empty pipe.
  task automatic check_latency(input string name);
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(name, lat, STAGES);
  endtask

  initial begin : monitor
    exp_t             e;
    logic             stalled;
    logic [LW-1:0]    hold_y;
    logic [LANES-1:0] hold_f;
    stalled = 1'b0;
    hold_y  = '0;
    hold_f  = '0;
    forever begin
      @(negedge clk);
      if (out_valid && stalled) begin
        check("stall_hold_y", y, hold_y);
        check("stall_hold_flag", flag, hold_f);
      end
      if (out_valid && out_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got y=0x%0h, want no result", y);
        end else begin
          e = exp_q.pop_front();
          check("result_y", y, e.y);
          check("result_flag", flag, e.flag);
        end
      end else begin
        stalled = out_valid;
        hold_y  = y;
        hold_f  = flag;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    mode = 2'b00;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_y", y, 0);
    check("reset_flag", flag, 0);
    check("reset_txn_count", txn_count, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b0;

    // First accept lands on the first edge with rst low; mode 01 adds the extra one.
    send(2'b01, 32'h0001_1234, 32'h0002_0001, 32'h0004_1236, 2'b00);
    in_valid = 1'b0;
    check_latency("latency_first");
    drain();

    // Back-to-back directed vectors: carries, borrows, mode 11, equal operands.
    send(2'b00, 32'h0010_FFFF, 32'h0020_0001, 32'h0030_0000, 2'b01);
    send(2'b10, 32'h0005_0003, 32'h0003_0005, 32'h0002_FFFE, 2'b01);
`ifdef LANE_ADDER_SAT_EN
    send(2'b11, 32'h0001_FFF0, 32'h0002_0020, 32'h0003_FFFF, 2'b01);
`else
    send(2'b11, 32'h0001_FFF0, 32'h0002_0020, 32'h0003_0010, 2'b01);
`endif
    send(2'b10, 32'h0000_1234, 32'h0001_1234, 32'hFFFF_0000, 2'b10);
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_0000, 2'b11);
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'hCAFE_F00D;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_output", out_valid, 0);
    check("txn_count_6", txn_count, 6);

    // Eight back-to-back transfers with out_ready low for four cycles.
    saw_in_ready_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(2'b00, {16'(i), 16'h1000 + 16'(i)}, {16'h0100, 16'(i)},
               {16'h0100 + 16'(i), 16'h1000 + 16'(2 * i)}, 2'b00);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_in_ready_fell", saw_in_ready_low, 1);
    check("txn_count_14", txn_count, 14);

    // Reset with two transfers in flight.
    send(2'b00, 32'h0001_0001, 32'h0001_0001, 32'h0002_0002, 2'b00);
    send(2'b00, 32'h0002_0002, 32'h0002_0002, 32'h0004_0004, 2'b00);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_txn_count", txn_count, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    a = 32'h1111_1111;
    b = 32'h2222_2222;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_discard_no_output", out_valid, 0);
    send(2'b10, 32'h0009_0000, 32'h0001_0001, 32'h0008_FFFF, 2'b01);
    in_valid = 1'b0;
    check_latency("latency_after_reset");
    drain();
    check("txn_count_after_reset", txn_count, 1);

    // 65537 deliveries from a fresh count wrap back to 1.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      send(2'b00, 32'h0001_0002, 32'h0003_0004, 32'h0004_0006, 2'b00);
    end
    in_valid = 1'b0;
    drain();
    check("txn_count_wrap", txn_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lane_adder_pipe.md
LANE_ADDER_PIPE -- requirements
Module: lane_adder_pipe

Interface
REQ-001 SHALL have parameter W, default 16, lane operand width in bits (legal range 2..64).
REQ-002 SHALL have parameter LANES, default 2, independent adder lanes (legal range 1..8).
REQ-003 SHALL have parameter STAGES, default 2, pipeline register stages (legal range 1..4).
REQ-004 SHALL have port clk  input  1  single clock; all flops rise-edge triggered.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand set offered.
REQ-007 SHALL have port in_ready  output  1  block accepts operand set this cycle.
REQ-008 SHALL have port mode  input  2  operation, sampled with operands.
REQ-009 SHALL have port a  input  LANES*W  packed operands A; lane k at bits [k*W+W-1:k*W].
REQ-010 SHALL have port b  input  LANES*W  packed operands B, same packing.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port y  output  LANES*W  packed results, same packing.
REQ-014 SHALL have port flag  output  LANES  per-lane carry/borrow/saturation flag.
REQ-015 SHALL have port txn_count  output  16  count of results delivered.

Function
REQ-016 SHALL compute per lane: mode 00 y=a+b; 01 y=a+b+1; 10 y=a-b; 11 per REQ-031/032; all modulo 2^W, unsigned.
REQ-017 SHALL set flag[k] to carry-out of bit W-1 for modes 00/01, and to borrow (a<b) for mode 10.
REQ-018 SHALL accept a transfer on clk edge when in_valid && in_ready; deliver when out_valid && out_ready.
REQ-019 SHALL implement STAGES valid-tagged stages; a stage advances when the next stage is empty or advancing.
REQ-020 SHALL drive in_ready = !stage0_valid || stage0_advancing (combinational, full throughput, no bubble).
REQ-021 SHALL give latency of exactly STAGES cycles from accepted input to out_valid with out_ready held high.
REQ-022 SHALL hold y, flag, out_valid stable while out_valid && !out_ready; no result lost or duplicated.
REQ-023 SHALL keep operands and mode of each transfer together through the pipe (mode sampled only at acceptance).
REQ-024 SHALL increment txn_count by 1 per delivered result, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL preserve order: results emerge in acceptance order; simultaneous accept and deliver in one cycle is legal.
REQ-026 SHALL ignore a and b when in_valid is low; y contents of invalid stages are don't-care but out_valid SHALL be 0.

Reset
REQ-027 SHALL, on rst high, asynchronously clear all stage valids, out_valid=0, y=0, flag=0, txn_count=0.
REQ-028 SHALL drive in_ready=1 during and after reset (pipe empty); transfers presented while rst is high are discarded.
REQ-029 SHALL discard all in-flight transfers on reset mid-operation; no out_valid until new acceptance + STAGES cycles.
REQ-030 SHALL release reset synchronously to clk in the sense that the first accept occurs on the first edge with rst low.

Configuration
REQ-031 SHALL, with macro LANE_ADDER_SAT_EN defined, make mode 11 unsigned saturating add: y=min(a+b, 2^W-1), flag[k]=1 iff clamped.
REQ-032 SHALL, without LANE_ADDER_SAT_EN, treat mode 11 identically to mode 00 (wrapping add, flag=carry).

Verification
REQ-033 SHALL cover: W=16,LANES=2,STAGES=2, mode 01, a={0x0001,0x1234}, b={0x0002,0x0001}, out_ready=1 -> 2 cycles later y={0x0004,0x1236}, flag=00.
REQ-034 SHALL cover: mode 00, lane0 a=0xFFFF b=0x0001 -> y0=0x0000 flag[0]=1; mode 10 a=0x0003 b=0x0005 -> y=0xFFFE flag=1.
REQ-035 SHALL cover: back-to-back 8 transfers, out_ready low for cycles 3..6 -> in_ready falls once pipe full, all 8 results delivered in order, y stable while stalled.
REQ-036 SHALL cover: mode 11, a=0xFFF0 b=0x0020 -> with LANE_ADDER_SAT_EN y=0xFFFF flag=1; without it y=0x0010 flag=1.
REQ-037 SHALL cover: rst asserted with 2 transfers in flight -> out_valid=0, txn_count=0 immediately; next transfer appears after STAGES cycles.
REQ-038 SHALL cover: 65537 deliveries -> txn_count reads 0x0001.
